// File: rtl/truth_table_sweep_checker.sv
// Sweeps all 32 {A,B,C,D,G} vectors through the function under test and checks F against GOLDEN.
// Optional: define TRUTH_TABLE_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module truth_table_sweep_checker #(
  parameter logic [31:0] GOLDEN        = 32'hFAF7DF6B,
  parameter int          SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [4:0] vec_out,
  input  logic       f_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic [4:0] first_fail_vec,
  output logic       first_fail_valid
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("truth_table_sweep_checker: SETTLE_CYCLES must be 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [3:0] r_settle;
  logic [4:0] r_vec;
  logic [5:0] r_err;
  logic [4:0] r_ff_vec;
  logic       r_ff_valid;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;

  logic       w_mismatch;
  logic [5:0] w_err_next;
  logic       w_stop;

  // Case inequality so an X/Z response in simulation counts as a failure.
  assign w_mismatch = (f_in !== GOLDEN[r_vec]);
  assign w_err_next = r_err + {5'd0, w_mismatch};

`ifdef TRUTH_TABLE_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_settle   <= 4'd0;
      r_vec      <= 5'd0;
      r_err      <= 6'd0;
      r_ff_vec   <= 5'd0;
      r_ff_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_APPLY;
            r_vec      <= 5'd0;
            r_settle   <= 4'd0;
            r_err      <= 6'd0;
            r_ff_valid <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
          end
        end
        S_APPLY: begin
          r_settle <= r_settle + 4'd1;
          if (r_settle == SETTLE_LAST) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_ff_valid) begin
            r_ff_vec   <= r_vec;
            r_ff_valid <= 1'b1;
          end
          // vec_out stays on the last (or failing) vector while in DONE.
          if (r_vec == 5'd31 || w_stop) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 6'd0);
          end else begin
            r_state  <= S_APPLY;
            r_vec    <= r_vec + 5'd1;
            r_settle <= 4'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vec_out          = r_vec;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_truth_table_sweep_checker.sv
// Directed bench for truth_table_sweep_checker; follows TRUTH_TABLE_STOP_ON_FAIL_EN when defined.
module tb_truth_table_sweep_checker;

  localparam int SET  = 2;
  localparam int FULL = 32 * (SET + 1) + 1;
`ifdef TRUTH_TABLE_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [4:0] vec_out;
  logic       f_in;
  logic       busy, done, pass, first_fail_valid;
  logic [5:0] err_count;
  logic [4:0] first_fail_vec;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mode     = 0;

  truth_table_sweep_checker #(
    .GOLDEN        (32'hFAF7DF6B),
    .SETTLE_CYCLES (SET)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .vec_out          (vec_out),
    .f_in             (f_in),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  always #5 clk = ~clk;

  // Behavioural F: zero only at the listed vectors.
  function automatic logic ref_f(input logic [4:0] v);
    case (v)
      5'd2, 5'd4, 5'd7, 5'd13, 5'd19, 5'd24, 5'd26: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    case (mode)
      1:       f_in = 1'b1;
      2:       f_in = 1'b0;
      3:       f_in = (vec_out == 5'd5 || vec_out == 5'd31) ? ~ref_f(vec_out) : ref_f(vec_out);
      default: f_in = ref_f(vec_out);
    endcase
  end

  function automatic int exp_done_rel(input int first);
    return STOP ? (first + 1) * (SET + 1) + 1 : FULL;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, output int rel);
    while (done !== 1'b1 && (cyc - t0) < 400) tick();
    rel = cyc - t0;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    #2 rst_n = 1'b0;
    #1;
    obs = {busy, done, pass, first_fail_valid, err_count, vec_out, first_fail_vec};
    n_checks++;
    if (obs !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected 0", obs);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    obs = {busy, done, pass, first_fail_valid, err_count, vec_out, first_fail_vec};
    n_checks++;
    if (obs !== 21'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h expected 0", obs);
    end
  endtask

  task automatic test_correct();
    int t0, rel;
    mode = 0;
    t0 = cyc;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL correct_busy_c1: got %b expected 1", busy); end
    wait_done(t0, rel);
    n_checks++;
    if (rel != FULL) begin n_fail++; $display("FAIL correct_done_cycle: got %0d expected %0d", rel, FULL); end
    n_checks++;
    if (err_count !== 6'd0) begin n_fail++; $display("FAIL correct_err: got %0d expected 0", err_count); end
    n_checks++;
    if (pass !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL correct_pass_busy: got %b%b expected 10", pass, busy);
    end
    n_checks++;
    if (first_fail_valid !== 1'b0) begin n_fail++; $display("FAIL correct_ffv: got %b expected 0", first_fail_valid); end
    n_checks++;
    if (vec_out !== 5'd31) begin n_fail++; $display("FAIL correct_vec: got %0d expected 31", vec_out); end
  endtask

  task automatic test_tied_one();
    int t0, rel;
    mode = 1;
    t0 = cyc;
    pulse_start();
    wait_done(t0, rel);
    n_checks++;
    if (rel != exp_done_rel(2)) begin
      n_fail++; $display("FAIL ones_done_cycle: got %0d expected %0d", rel, exp_done_rel(2));
    end
    n_checks++;
    if (err_count !== (STOP ? 6'd1 : 6'd7)) begin
      n_fail++; $display("FAIL ones_err: got %0d expected %0d", err_count, STOP ? 1 : 7);
    end
    n_checks++;
    if (first_fail_vec !== 5'd2 || first_fail_valid !== 1'b1) begin
      n_fail++; $display("FAIL ones_first: got %0d/%b expected 2/1", first_fail_vec, first_fail_valid);
    end
    n_checks++;
    if (pass !== 1'b0) begin n_fail++; $display("FAIL ones_pass: got %b expected 0", pass); end
    n_checks++;
    if (vec_out !== (STOP ? 5'd2 : 5'd31)) begin
      n_fail++; $display("FAIL ones_vec: got %0d expected %0d", vec_out, STOP ? 2 : 31);
    end
  endtask

  task automatic test_tied_zero();
    int t0, rel;
    mode = 2;
    t0 = cyc;
    pulse_start();
    wait_done(t0, rel);
    n_checks++;
    if (rel != exp_done_rel(0)) begin
      n_fail++; $display("FAIL zeros_done_cycle: got %0d expected %0d", rel, exp_done_rel(0));
    end
    n_checks++;
    if (err_count !== (STOP ? 6'd1 : 6'd25)) begin
      n_fail++; $display("FAIL zeros_err: got %0d expected %0d", err_count, STOP ? 1 : 25);
    end
    n_checks++;
    if (first_fail_vec !== 5'd0 || first_fail_valid !== 1'b1) begin
      n_fail++; $display("FAIL zeros_first: got %0d/%b expected 0/1", first_fail_vec, first_fail_valid);
    end
    n_checks++;
    if (pass !== 1'b0) begin n_fail++; $display("FAIL zeros_pass: got %b expected 0", pass); end
  endtask

  task automatic test_boundary();
    int t0, rel;
    mode = 3;
    t0 = cyc;
    pulse_start();
    wait_done(t0, rel);
    n_checks++;
    if (rel != exp_done_rel(5)) begin
      n_fail++; $display("FAIL bound_done_cycle: got %0d expected %0d", rel, exp_done_rel(5));
    end
    n_checks++;
    if (err_count !== (STOP ? 6'd1 : 6'd2)) begin
      n_fail++; $display("FAIL bound_err: got %0d expected %0d", err_count, STOP ? 1 : 2);
    end
    n_checks++;
    if (first_fail_vec !== 5'd5) begin n_fail++; $display("FAIL bound_first: got %0d expected 5", first_fail_vec); end
    n_checks++;
    if (vec_out !== (STOP ? 5'd5 : 5'd31)) begin
      n_fail++; $display("FAIL bound_vec: got %0d expected %0d", vec_out, STOP ? 5 : 31);
    end
  endtask

  task automatic test_reset_mid();
    int t0, t1, rel;
    logic [20:0] obs;
    mode = 0;
    t0 = cyc;
    pulse_start();
    while (cyc - t0 < 40) tick();
    rst_n = 1'b0;
    #1;
    obs = {busy, done, pass, first_fail_valid, err_count, vec_out, first_fail_vec};
    n_checks++;
    if (obs !== 21'd0) begin n_fail++; $display("FAIL midreset_async: got %h expected 0", obs); end
    tick();
    tick();
    rst_n = 1'b1;
    while (cyc - t0 < 50) tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 5'd0) begin
      n_fail++; $display("FAIL midreset_idle: got busy=%b done=%b vec=%0d expected 0 0 0", busy, done, vec_out);
    end
    t1 = cyc;
    pulse_start();
    wait_done(t1, rel);
    n_checks++;
    if (t1 - t0 + rel != 147) begin
      n_fail++; $display("FAIL midreset_done_cycle: got %0d expected 147", t1 - t0 + rel);
    end
    n_checks++;
    if (pass !== 1'b1) begin n_fail++; $display("FAIL midreset_pass: got %b expected 1", pass); end
  endtask

  task automatic test_restart();
    int t0, t1, rel;
    mode = 1;
    t0 = cyc;
    pulse_start();
    if (!STOP) begin
      while (cyc - t0 < 10) tick();
      pulse_start();
      while (cyc - t0 < 60) tick();
      pulse_start();
    end
    wait_done(t0, rel);
    n_checks++;
    if (rel != exp_done_rel(2)) begin
      n_fail++; $display("FAIL restart_ignored_done: got %0d expected %0d", rel, exp_done_rel(2));
    end
    n_checks++;
    if (err_count !== (STOP ? 6'd1 : 6'd7)) begin
      n_fail++; $display("FAIL restart_ignored_err: got %0d expected %0d", err_count, STOP ? 1 : 7);
    end
    mode = 0;
    t1 = cyc;
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || err_count !== 6'd0) begin
      n_fail++; $display("FAIL restart_clear: got done=%b err=%0d expected 0 0", done, err_count);
    end
    n_checks++;
    if (busy !== 1'b1 || vec_out !== 5'd0 || first_fail_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart_state: got busy=%b vec=%0d ffv=%b expected 1 0 0", busy, vec_out, first_fail_valid);
    end
    wait_done(t1, rel);
    n_checks++;
    if (rel != FULL || pass !== 1'b1) begin
      n_fail++; $display("FAIL restart_rerun: got cycle=%0d pass=%b expected %0d 1", rel, pass, FULL);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, rel;
    mode = 0;
    t0 = cyc;
    start = 1'b1;
    tick();
    wait_done(t0, rel);
    n_checks++;
    if (rel != FULL) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected %0d", rel, FULL); end
    t1 = cyc;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || vec_out !== 5'd0) begin
      n_fail++; $display("FAIL b2b_restart: got busy=%b done=%b vec=%0d expected 1 0 0", busy, done, vec_out);
    end
    wait_done(t1, rel);
    n_checks++;
    if (rel != FULL || pass !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: got cycle=%0d pass=%b expected %0d 1", rel, pass, FULL);
    end
    tick();
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || vec_out !== 5'd31) begin
      n_fail++; $display("FAIL b2b_sticky: got done=%b busy=%b vec=%0d expected 1 0 31", done, busy, vec_out);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_tied_one();
    test_tied_zero();
    test_boundary();
    test_reset_mid();
    test_restart();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
